// File: rtl/dcp_pkg.sv
// Shared types for the DCP line responder: line/transid types and the
// per-request queue entry carried from accept to response.
package dcp_pkg;

   localparam int LINE_BYTES = 64;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int TID_W      = 6;
   // Entry index field is sized for up to 256 store lines.
   localparam int IDX_W      = 8;
   localparam int CNT_W      = 3;

   typedef logic [LINE_W-1:0] line_t;
   typedef logic [TID_W-1:0]  tid_t;

   typedef struct packed {
      tid_t             transid;
      logic [IDX_W-1:0] idx;
      logic [CNT_W-1:0] cnt;
   } resp_entry_t;

   // A latency of 0 behaves like 1, so the countdown starts at max(lat,1)-1.
   function automatic logic [CNT_W-1:0] lat_to_cnt(input logic [CNT_W-1:0] lat);
      return (lat == '0) ? '0 : lat - 1'b1;
   endfunction

endpackage

// File: rtl/dcp_line_responder_if.sv
// Request/response line bus between the prefetcher (master) and memory (slave).
interface dcp_line_responder_if #(
   parameter int ADDR_W = 32,
   parameter int TID_W  = dcp_pkg::TID_W,
   parameter int LINE_W = dcp_pkg::LINE_W
);
   logic              mem_req_val;
   logic              mem_req_rdy;
   logic [TID_W-1:0]  mem_req_transid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_resp_val;
   logic [TID_W-1:0]  mem_resp_transid;
   logic [LINE_W-1:0] mem_resp_data;

   modport master (
      output mem_req_val, mem_req_transid, mem_req_addr,
      input  mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
   );

   modport slave (
      input  mem_req_val, mem_req_transid, mem_req_addr,
      output mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data
   );
endinterface

// File: rtl/dcp_resp_fifo.sv
// In-order request queue; every entry counts down its latency in parallel,
// but only the head may leave, so late entries that reach zero just wait.
module dcp_resp_fifo
   import dcp_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  resp_entry_t               push_entry,
   input  logic                      pop,
   output resp_entry_t               head,
   output logic                      head_rdy,
   output logic                      full,
   output logic [$clog2(QDEPTH):0]   count
);
   localparam int PTR_W = $clog2(QDEPTH);

   resp_entry_t [QDEPTH-1:0] ent_q, ent_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]           count_q, count_d;

   always_comb begin
      ent_d    = ent_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      for (int i = 0; i < QDEPTH; i++) begin
         if (ent_q[i].cnt != '0)
            ent_d[i].cnt = ent_q[i].cnt - 1'b1;
      end
      if (push) begin
         ent_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q    <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ent_q    <= ent_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head     = ent_q[rd_ptr_q];
   assign head_rdy = (count_q != '0) && (head.cnt == '0);
   assign full     = (count_q == (PTR_W+1)'(QDEPTH));
   assign count    = count_q;

endmodule

// File: rtl/dcp_line_responder.sv
// Memory-side line responder: queues line reads, answers each in order after
// lat_cfg cycles with a line from a side-loaded backing store.
module dcp_line_responder
   import dcp_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = dcp_pkg::LINE_BYTES,
   parameter int LINE_W     = dcp_pkg::LINE_W,
   parameter int TID_W      = dcp_pkg::TID_W,
   parameter int NUM_LINES  = 16,
   parameter int QDEPTH     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   dcp_line_responder_if.slave          mem,
   input  logic [2:0]                   lat_cfg,
   input  logic                         ld_val,
   input  logic [$clog2(NUM_LINES)-1:0] ld_idx,
   input  logic [LINE_W-1:0]            ld_data,
   output logic [$clog2(QDEPTH):0]      outstanding
);
   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int LIDX_W = $clog2(NUM_LINES);

   logic [LINE_W-1:0] store_q [NUM_LINES];

   logic              full, head_rdy, accept;
   logic [LIDX_W-1:0] req_idx, head_idx;
   resp_entry_t       push_ent, head;

   logic              resp_val_q, resp_val_d;
   logic [TID_W-1:0]  resp_tid_q, resp_tid_d;
   logic [LINE_W-1:0] resp_data_q, resp_data_d;

   // rdy depends only on registered occupancy, never on mem_req_val.
   assign mem.mem_req_rdy = !full;
   assign accept          = mem.mem_req_val && !full;

   // Offset bits are dropped and upper bits wrap modulo the store depth.
   assign req_idx  = mem.mem_req_addr[OFF_W +: LIDX_W];
   assign head_idx = head.idx[LIDX_W-1:0];

   always_comb begin
      push_ent         = '0;
      push_ent.transid = tid_t'(mem.mem_req_transid);
      push_ent.idx     = IDX_W'(req_idx);
      push_ent.cnt     = lat_to_cnt(lat_cfg);
   end

   dcp_resp_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept),
      .push_entry (push_ent),
      .pop        (head_rdy),
      .head       (head),
      .head_rdy   (head_rdy),
      .full       (full),
      .count      (outstanding)
   );

   // The store is read at the pop edge, so a same-edge preload lands after the read.
   always_comb begin
      resp_val_d  = 1'b0;
      resp_tid_d  = resp_tid_q;
      resp_data_d = resp_data_q;
      if (head_rdy) begin
         resp_val_d  = 1'b1;
         resp_tid_d  = TID_W'(head.transid);
         resp_data_d = store_q[head_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_val_q  <= 1'b0;
         resp_tid_q  <= '0;
         resp_data_q <= '0;
      end else begin
         resp_val_q  <= resp_val_d;
         resp_tid_q  <= resp_tid_d;
         resp_data_q <= resp_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ld_val)
         store_q[ld_idx] <= ld_data;
   end

   assign mem.mem_resp_val     = resp_val_q;
   assign mem.mem_resp_transid = resp_tid_q;
   assign mem.mem_resp_data    = resp_data_q;

   logic unused_bits;
   assign unused_bits = ^{mem.mem_req_addr[ADDR_W-1:OFF_W+LIDX_W],
                          mem.mem_req_addr[OFF_W-1:0],
                          head.idx[IDX_W-1:LIDX_W], head.cnt};

endmodule

// File: tb/tb_dcp_line_responder.sv
// Directed bench: stimulus pushes expected responses (tid, line, answer cycle)
// into a scoreboard; a negedge monitor pops and compares every response.
module tb_dcp_line_responder;
   import dcp_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] lat_cfg;
   logic       ld_val;
   logic [3:0] ld_idx;
   line_t      ld_data;
   logic [2:0] outstanding;

   always #5 clk = ~clk;

   dcp_line_responder_if mem_if ();

   dcp_line_responder dut (
      .clk         (clk),
      .rst         (rst),
      .mem         (mem_if),
      .lat_cfg     (lat_cfg),
      .ld_val      (ld_val),
      .ld_idx      (ld_idx),
      .ld_data     (ld_data),
      .outstanding (outstanding)
   );

   typedef struct {
      logic [5:0] tid;
      line_t      data;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   last_exp = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic line_t mk_line(input int base);
      line_t l;
      for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'(base + k);
      return l;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every response must match the oldest expectation exactly.
   always @(negedge clk) begin
      exp_t e;
      if (mem_if.mem_resp_val === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: got tid %0d at cycle %0d, expected none",
                     mem_if.mem_resp_transid, cyc);
         end else begin
            e = sb.pop_front();
            chk("resp_tid", 64'(mem_if.mem_resp_transid), 64'(e.tid));
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            n_cmp++;
            if (mem_if.mem_resp_data !== e.data) begin
               n_err++;
               $display("FAIL resp_data tid %0d: got %h expected %h",
                        e.tid, mem_if.mem_resp_data, e.data);
            end
         end
      end
   end

   task automatic preload(input logic [3:0] idx, input line_t d);
      ld_val  = 1'b1;
      ld_idx  = idx;
      ld_data = d;
      @(negedge clk);
      ld_val  = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [5:0] tid, input logic [31:0] addr,
                       input line_t exp_data, output int acc);
      int   waited;
      int   lat;
      exp_t e;
      waited = 0;
      mem_if.mem_req_val     = 1'b1;
      mem_if.mem_req_transid = tid;
      mem_if.mem_req_addr    = addr;
      while (mem_if.mem_req_rdy !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (mem_if.mem_req_rdy !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout tid %0d: got rdy=0 for 40 cycles, expected rdy=1", tid);
         mem_if.mem_req_val = 1'b0;
         acc = -1;
      end else begin
         acc   = cyc + 1;
         lat   = (lat_cfg == 3'd0) ? 1 : int'(lat_cfg);
         e.cyc = acc + lat;
         if (e.cyc <= last_exp) e.cyc = last_exp + 1;
         last_exp = e.cyc;
         e.tid  = tid;
         e.data = exp_data;
         sb.push_back(e);
         @(negedge clk);
         mem_if.mem_req_val = 1'b0;
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d responses missing, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int a1, a2, a3, a4, a5;
      mem_if.mem_req_val     = 1'b0;
      mem_if.mem_req_transid = '0;
      mem_if.mem_req_addr    = '0;
      lat_cfg = 3'd1;
      ld_val  = 1'b0;
      ld_idx  = '0;
      ld_data = '0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_resp_val", 64'(mem_if.mem_resp_val), 64'd0);
      chk("reset_resp_tid", 64'(mem_if.mem_resp_transid), 64'd0);
      chk("reset_resp_data_zero", 64'(mem_if.mem_resp_data == '0), 64'd1);
      chk("reset_outstanding", 64'(outstanding), 64'd0);
      chk("reset_rdy", 64'(mem_if.mem_req_rdy), 64'd1);

      preload(4'd8,  mk_line(1));
      preload(4'd9,  mk_line(100));
      preload(4'd10, mk_line(50));
      preload(4'd1,  mk_line(300));

      // Single unaligned request, latency 3.
      lat_cfg = 3'd3;
      send(6'd5, 32'h204, mk_line(1), a1);
      drain();

      // Back-to-back, latency 1: one in flight at a time.
      lat_cfg = 3'd1;
      send(6'd1, 32'h200, mk_line(1), a1);
      chk("b2b_outstanding_le1", 64'(outstanding <= 3'd1), 64'd1);
      send(6'd2, 32'h240, mk_line(100), a2);
      chk("b2b_outstanding_le1", 64'(outstanding <= 3'd1), 64'd1);
      send(6'd3, 32'h280, mk_line(50), a3);
      chk("b2b_outstanding_le1", 64'(outstanding <= 3'd1), 64'd1);
      chk("b2b_consecutive_accepts", 64'(a3 - a1), 64'd2);
      drain();

      // Fill the queue, latency 7.
      lat_cfg = 3'd7;
      send(6'd10, 32'h200, mk_line(1), a1);
      send(6'd11, 32'h240, mk_line(100), a2);
      send(6'd12, 32'h280, mk_line(50), a3);
      send(6'd13, 32'h200, mk_line(1), a4);
      chk("full_outstanding", 64'(outstanding), 64'd4);
      chk("full_rdy_low", 64'(mem_if.mem_req_rdy), 64'd0);
      send(6'd14, 32'h240, mk_line(100), a5);
      chk("full_fifth_accept_cycle", 64'(a5 - a1), 64'd8);
      drain();

      // Preload to idx 9 on the same edge its response pops.
      lat_cfg = 3'd2;
      send(6'd20, 32'h240, mk_line(100), a1);
      @(negedge clk);
      ld_val  = 1'b1;
      ld_idx  = 4'd9;
      ld_data = mk_line(200);
      @(negedge clk);
      ld_val  = 1'b0;
      send(6'd21, 32'h240, mk_line(200), a2);
      drain();

      // Reset with two requests pending: they must vanish.
      lat_cfg = 3'd7;
      send(6'd30, 32'h200, mk_line(1), a1);
      send(6'd31, 32'h240, mk_line(200), a2);
      chk("prereset_outstanding", 64'(outstanding), 64'd2);
      rst = 1'b1;
      sb.delete();
      last_exp = 0;
      @(negedge clk);
      rst = 1'b0;
      chk("postreset_outstanding", 64'(outstanding), 64'd0);
      chk("postreset_rdy", 64'(mem_if.mem_req_rdy), 64'd1);
      chk("postreset_resp_val", 64'(mem_if.mem_resp_val), 64'd0);
      repeat (12) @(negedge clk);

      // Latency 0 acts as 1; address 0x440 wraps to idx 1.
      lat_cfg = 3'd0;
      send(6'd40, 32'h440, mk_line(300), a1);
      drain();

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dcp_line_responder.md
Name: dcp_line_responder

Overview:
- Synthesizable memory-side responder for the DCP-style line interface that the vector-file prefetcher drives as the initiator.
- Accepts line read requests (val/rdy, transid, byte address) and returns one 512-bit line per request, tagged with the same transid, after a programmable latency.
- Holds a small backing line store that is preloaded through a side port.
- Used as the memory end in unit and integration benches, and as a stand-in for the DCP memory path in FPGA bring-up.

Parameters:
- ADDR_W, 32, request byte-address width
- LINE_BYTES, 64, bytes per cache line; power of two
- LINE_W, 512, line data width in bits; equals LINE_BYTES*8
- TID_W, 6, transaction id width
- NUM_LINES, 16, backing store depth in lines; power of two
- QDEPTH, 4, outstanding request queue depth; power of two, at least 2

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_req_val  in  1  request valid
- mem_req_rdy  out  1  responder can accept a request this cycle
- mem_req_transid  in  TID_W  request transaction id
- mem_req_addr  in  ADDR_W  request byte address
- mem_resp_val  out  1  response valid; one-cycle pulse per request, no back-pressure
- mem_resp_transid  out  TID_W  transid of the request being answered
- mem_resp_data  out  LINE_W  line data; element 0 in bits [31:0]
- lat_cfg  in  3  response latency in cycles; 0 is treated as 1
- ld_val  in  1  preload write enable
- ld_idx  in  log2(NUM_LINES)  preload line index
- ld_data  in  LINE_W  preload line data
- outstanding  out  log2(QDEPTH)+1  number of queued, unanswered requests

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: mem_resp_val=0, mem_resp_transid=0, mem_resp_data=0, outstanding=0, queue empty.
  - The backing store is not reset.
  - Reset mid-operation drops all pending requests; no response is issued for them.
- Handshake:
  - A request is accepted on a cycle with mem_req_val && mem_req_rdy.
  - mem_req_rdy = !full, registered-state only, with no combinational path from mem_req_val.
  - When full, a pop in the same cycle does not raise rdy until the next cycle.
- Address mapping: idx = (mem_req_addr >> log2(LINE_BYTES)) mod NUM_LINES.
  - Offset bits within the line are ignored, so unaligned addresses return the whole containing line.
  - Upper bits wrap silently.
- Queue:
  - In-order FIFO of QDEPTH entries, each holding {transid, idx, cnt}.
  - On accept, cnt is loaded with max(lat_cfg,1)-1.
  - Every cycle, each valid entry with cnt>0 decrements.
- Response:
  - When the head entry has cnt==0, the next cycle drives mem_resp_val=1 with its transid and store[idx], and the head pops.
  - A request accepted at edge T therefore answers at edge T+max(lat_cfg,1), unless it is stalled behind the head.
  - At most one response per cycle. Responses are strictly in order.
  - A non-head entry reaching cnt==0 holds at 0 until it becomes head.
  - If lat_cfg decreases mid-stream, later entries still wait behind earlier ones.
- Data sampling:
  - store[idx] is read in the pop cycle, so a preload landing before that cycle is visible.
  - If ld_val writes the same idx in the pop cycle, the old data is returned (read-before-write).
- Outputs between responses: mem_resp_val=0; mem_resp_transid and mem_resp_data hold their last values.
- Simultaneous accept and pop: both happen; outstanding is unchanged.
- outstanding is the registered count of valid queue entries.
- Depth bound: with lat_cfg=1 and continuous val, the queue never fills. Throughput is one request per cycle after the first.

Decomposition:
- Shared package dcp_pkg holds:
  - LINE_BYTES, LINE_W, TID_W constants
  - typedef line_t (LINE_W bits)
  - typedef tid_t
  - typedef resp_entry_t {tid_t transid; idx; cnt}
- One natural sub-module: dcp_resp_fifo, a parameterized in-order FIFO with per-entry countdown and head-ready flag.
- The top level holds the backing store, address mapping and response register.

Test Plan:
- Single request, lat_cfg=3: preload idx 8 with words 1..16; request addr 0x204, tid 5 → mem_resp_val pulses once, exactly 3 cycles after accept, tid 5, data word0=1, word15=16.
- Back-to-back requests, lat_cfg=1: 3 requests on consecutive cycles, tids 1,2,3, addrs 0x200/0x240/0x280 → 3 consecutive response cycles, in order, correct lines, outstanding ≤1.
- Full queue, lat_cfg=7: 5 requests held valid → rdy drops after 4 accepts, outstanding=4; the 5th is accepted only on the cycle after the first pop.
- Read-before-write: ld_val writes idx 9 in the same cycle its pending response pops → old line returned; a second request to idx 9 returns the new line.
- Reset mid-flight: 2 requests outstanding, rst held 1 cycle → no responses follow, outstanding=0, rdy=1 the cycle after reset.
- lat_cfg=0 with address wrap: request addr 0x400+0x40 with NUM_LINES=16 → response 1 cycle after accept, carrying store[1].
